// File: rtl/bank_isu_credit_pool.sv
`default_nettype none
// ============================================================================
// Module   : bank_isu_credit_pool
// Purpose  : Per-channel read-credit manager for the bank issue queue; parks
//            reads that arrive without credit and grants them oldest-first.
// Revision : 1.0
// ============================================================================
module bank_isu_credit_pool #(
    parameter int CHANNEL_NUM = 4,
    parameter int PTR_WIDTH   = 6,
    parameter int CREDIT_INIT = 8,
    localparam int DEPTH = 1 << PTR_WIDTH,
    localparam int CH_W  = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1,
    localparam int CNT_W = $clog2(CREDIT_INIT + 1)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                iq_enqueue,
    input  logic [PTR_WIDTH-1:0]                iq_write_ptr,
    input  logic                                htu_op_is_read,
    input  logic [CH_W-1:0]                     htu_ch_id,
    input  logic                                iq_dequeue,
    input  logic [PTR_WIDTH-1:0]                iq_dequeue_ptr,
    input  logic [PTR_WIDTH-1:0]                iq_bottom_ptr,
    input  logic [DEPTH-1:0]                    iq_valid_array,
    input  logic [CHANNEL_NUM*DEPTH-1:0]        entry_req_from_ch,
    input  logic [CHANNEL_NUM-1:0]              channels_credit_release,
    output logic [DEPTH-1:0]                    credit_allow_array,
    output logic [CHANNEL_NUM*CNT_W-1:0]        channels_credit_num,
    output logic [CHANNEL_NUM*(PTR_WIDTH+1)-1:0] channels_pending_num,
    output logic                                credit_err
);

    localparam int               c_pend_w   = PTR_WIDTH + 1;
    localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'(CREDIT_INIT);

    logic [DEPTH-1:0]      r_allow;
    logic [DEPTH-1:0]      w_allow_nxt;
    logic [CNT_W-1:0]      r_cnt      [CHANNEL_NUM];
    logic [CNT_W-1:0]      w_cnt_nxt  [CHANNEL_NUM];
    logic [c_pend_w-1:0]   r_pend     [CHANNEL_NUM];
    logic [c_pend_w-1:0]   w_pend_nxt [CHANNEL_NUM];
    logic                  r_err;
    logic                  w_err_nxt;

    logic [CHANNEL_NUM-1:0] w_has_credit;
    logic [CHANNEL_NUM-1:0] w_has_pend;
    logic [CHANNEL_NUM-1:0] w_enq_rd;
    logic [CHANNEL_NUM-1:0] w_grant;
    logic [CHANNEL_NUM-1:0] w_stall;
    logic [CHANNEL_NUM-1:0] w_alloc;
    logic [CHANNEL_NUM-1:0] w_park;
    logic [CHANNEL_NUM-1:0] w_sat;
    logic [CHANNEL_NUM-1:0] w_found;
    logic [DEPTH-1:0]       w_nocred [CHANNEL_NUM];
    logic [PTR_WIDTH-1:0]   w_tgt    [CHANNEL_NUM];
    logic                   w_ch_ok;
    logic                   w_rd_allow;
    logic                   w_enq_allow;

    always_comb begin
        for (int c = 0; c < CHANNEL_NUM; c++) begin
            w_has_credit[c] = (r_cnt[c] != '0);
            w_has_pend[c]   = (r_pend[c] != '0);
            w_enq_rd[c]     = iq_enqueue & htu_op_is_read & (htu_ch_id == CH_W'(c));
            w_nocred[c]     = iq_valid_array & ~r_allow & entry_req_from_ch[c*DEPTH +: DEPTH];
            w_grant[c]      = w_has_credit[c] & w_has_pend[c] & (|w_nocred[c]);
            // Parked count says work exists but no unallowed entry is visible.
            w_stall[c]      = w_has_credit[c] & w_has_pend[c] & ~(|w_nocred[c]);
            w_alloc[c]      = w_grant[c] | (w_enq_rd[c] & w_has_credit[c] & ~w_has_pend[c]);
            w_park[c]       = w_enq_rd[c] & (~w_has_credit[c] | w_has_pend[c]);
        end
    end

    // Oldest-first target: scan upward from the queue bottom with wrap.
    always_comb begin
        for (int c = 0; c < CHANNEL_NUM; c++) begin
            w_tgt[c]   = '0;
            w_found[c] = 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                if (!w_found[c] && w_nocred[c][iq_bottom_ptr + PTR_WIDTH'(k)]) begin
                    w_tgt[c]   = iq_bottom_ptr + PTR_WIDTH'(k);
                    w_found[c] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int c = 0; c < CHANNEL_NUM; c++) begin
            w_cnt_nxt[c]  = r_cnt[c];
            w_pend_nxt[c] = r_pend[c];
            w_sat[c]      = 1'b0;
            if (!w_stall[c]) begin
                if (w_alloc[c] && !channels_credit_release[c]) begin
                    w_cnt_nxt[c] = r_cnt[c] - CNT_W'(1);
                end else if (!w_alloc[c] && channels_credit_release[c]) begin
                    if (r_cnt[c] == c_cnt_init) begin
                        w_sat[c] = 1'b1;
                    end else begin
                        w_cnt_nxt[c] = r_cnt[c] + CNT_W'(1);
                    end
                end
                if (w_park[c] && !w_grant[c]) begin
                    w_pend_nxt[c] = r_pend[c] + c_pend_w'(1);
                end else if (!w_park[c] && w_grant[c]) begin
                    w_pend_nxt[c] = r_pend[c] - c_pend_w'(1);
                end
            end
        end
    end

    always_comb begin
        w_ch_ok    = 1'b0;
        w_rd_allow = 1'b0;
        for (int c = 0; c < CHANNEL_NUM; c++) begin
            if (htu_ch_id == CH_W'(c)) begin
                w_ch_ok    = 1'b1;
                w_rd_allow = w_has_credit[c] & ~w_has_pend[c];
            end
        end
        w_enq_allow = htu_op_is_read ? w_rd_allow : 1'b1;

        // Later writes win: dequeue, then grants, then enqueue.
        w_allow_nxt = r_allow;
        if (iq_dequeue) begin
            w_allow_nxt[iq_dequeue_ptr] = 1'b0;
        end
        for (int c = 0; c < CHANNEL_NUM; c++) begin
            if (w_grant[c]) begin
                w_allow_nxt[w_tgt[c]] = 1'b1;
            end
        end
        if (iq_enqueue) begin
            w_allow_nxt[iq_write_ptr] = w_enq_allow;
        end

        w_err_nxt = r_err | (|w_stall) | (|w_sat) |
                    (iq_enqueue & htu_op_is_read & ~w_ch_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_allow <= '0;
            r_err   <= 1'b0;
            for (int c = 0; c < CHANNEL_NUM; c++) begin
                r_cnt[c]  <= c_cnt_init;
                r_pend[c] <= '0;
            end
        end else begin
            r_allow <= w_allow_nxt;
            r_err   <= w_err_nxt;
            for (int c = 0; c < CHANNEL_NUM; c++) begin
                r_cnt[c]  <= w_cnt_nxt[c];
                r_pend[c] <= w_pend_nxt[c];
            end
        end
    end

    assign credit_allow_array = r_allow;
    assign credit_err         = r_err;

    for (genvar g = 0; g < CHANNEL_NUM; g++) begin : g_pack
        assign channels_credit_num[g*CNT_W +: CNT_W]        = r_cnt[g];
        assign channels_pending_num[g*c_pend_w +: c_pend_w] = r_pend[g];
    end

endmodule
`default_nettype wire
